// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the priority-encoder family.
// The helper is sized for the widest legal request vector; callers zero-extend.
package prio_enc_pkg;

  localparam int MAX_N = 256;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scan_state_t;

  // True when at most one bit of vec is set.
  function automatic logic onehot_or_zero(input logic [MAX_N-1:0] vec);
    return (vec & (vec - MAX_N'(1))) == '0;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational N-input priority encoder; MSB_FIRST selects which end wins.
module prio_enc_core #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1,
  localparam int W        = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Later iterations overwrite earlier ones, so the loop direction sets priority.
  always_comb begin
    idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/prio_enc_scan.sv
// Captures a request vector and streams out the index of each set bit in
// priority order, one per accepted beat, with last/none flags.
module prio_enc_scan
  import prio_enc_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = $clog2(N),
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none
);

  scan_state_t  state;
  logic [N-1:0] pend;
  logic         zero_f;
  logic [W-1:0] core_idx;
  logic         core_any;
  logic         scan;
  logic         take_in;
  logic         take_out;

  prio_enc_core #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .vec (pend),
    .idx (core_idx),
    .any (core_any)
  );

  assign scan      = (state == SCAN);
  assign out_valid = scan;
  assign out_idx   = scan ? core_idx : '0;
  assign out_none  = scan & zero_f;
  assign out_last  = scan & (zero_f | (core_any & onehot_or_zero(MAX_N'(pend))));

  // Accepting on the final beat lets the next vector follow with no bubble.
  assign in_ready  = !scan | (out_ready & out_last);
  assign take_in   = in_valid & in_ready;
  assign take_out  = scan & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend   <= '0;
      zero_f <= 1'b0;
    end else if (take_in) begin
      state  <= SCAN;
      pend   <= in_vec;
      zero_f <= (in_vec == '0);
    end else if (take_out) begin
      pend <= pend & ~(N'(1) << core_idx);
      if (out_last) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_prio_enc_scan.sv
// Directed and model-scored bench for prio_enc_scan at N=8 (both orders) and N=13.
module tb_prio_enc_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Index 0: MSB_FIRST=1, index 1: MSB_FIRST=0
  logic       in_valid8 [2];
  logic       in_ready8 [2];
  logic [7:0] in_vec8   [2];
  logic       out_valid8[2];
  logic       out_ready8[2];
  logic [2:0] out_idx8  [2];
  logic       out_last8 [2];
  logic       out_none8 [2];

  logic        iv13, ir13, ov13, or13, ol13, on13;
  logic [12:0] vec13;
  logic [3:0]  idx13;

  prio_enc_scan #(.N(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8[0]), .in_ready(in_ready8[0]), .in_vec(in_vec8[0]),
    .out_valid(out_valid8[0]), .out_ready(out_ready8[0]), .out_idx(out_idx8[0]),
    .out_last(out_last8[0]), .out_none(out_none8[0])
  );

  prio_enc_scan #(.N(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8[1]), .in_ready(in_ready8[1]), .in_vec(in_vec8[1]),
    .out_valid(out_valid8[1]), .out_ready(out_ready8[1]), .out_idx(out_idx8[1]),
    .out_last(out_last8[1]), .out_none(out_none8[1])
  );

  prio_enc_scan #(.N(13), .MSB_FIRST(1)) u_n13 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv13), .in_ready(ir13), .in_vec(vec13),
    .out_valid(ov13), .out_ready(or13), .out_idx(idx13),
    .out_last(ol13), .out_none(on13)
  );

  int nchecks = 0;
  int nerr    = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]      vec;
    int              d;
    int              beats;
    logic [7:0][2:0] exp;
    logic            none;
  } rec_t;

  function automatic logic [7:0][2:0] seq(input int e0 = 0, input int e1 = 0,
                                           input int e2 = 0, input int e3 = 0,
                                           input int e4 = 0, input int e5 = 0,
                                           input int e6 = 0, input int e7 = 0);
    logic [7:0][2:0] r;
    r[0] = 3'(e0); r[1] = 3'(e1); r[2] = 3'(e2); r[3] = 3'(e3);
    r[4] = 3'(e4); r[5] = 3'(e5); r[6] = 3'(e6); r[7] = 3'(e7);
    return r;
  endfunction

  // Apply one vector from IDLE with out_ready held high and check every beat.
  task automatic apply_rec(input rec_t r, input int tag);
    int d;
    d = r.d;
    in_vec8[d]    = r.vec;
    in_valid8[d]  = 1'b1;
    out_ready8[d] = 1'b1;
    chk($sformatf("v%0d_in_ready_idle", tag), in_ready8[d], 1);
    @(posedge clk); #1;
    in_valid8[d] = 1'b0;
    for (int b = 0; b < r.beats; b++) begin
      chk($sformatf("v%0d_b%0d_valid", tag, b), out_valid8[d], 1);
      chk($sformatf("v%0d_b%0d_idx", tag, b), out_idx8[d], r.exp[b]);
      chk($sformatf("v%0d_b%0d_last", tag, b), out_last8[d], (b == r.beats - 1) ? 1 : 0);
      chk($sformatf("v%0d_b%0d_none", tag, b), out_none8[d], r.none);
      chk($sformatf("v%0d_b%0d_in_ready", tag, b), in_ready8[d], (b == r.beats - 1) ? 1 : 0);
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d_idle_after", tag), out_valid8[d], 0);
  endtask

  // N=13 run scored by an ordered list of set-bit indices; out_ready may stall.
  task automatic run13(input logic [12:0] v, input bit rand_ready, input int tag);
    int exp_q[$];
    int ptr;
    int cyc;
    for (int i = 12; i >= 0; i--) if (v[i]) exp_q.push_back(i);
    if (exp_q.size() == 0) exp_q.push_back(0);
    vec13 = v;
    iv13  = 1'b1;
    or13  = 1'b1;
    chk($sformatf("n13_%0d_in_ready", tag), ir13, 1);
    @(posedge clk); #1;
    iv13 = 1'b0;
    ptr = 0;
    cyc = 0;
    while (ptr < exp_q.size() && cyc < 200) begin
      or13 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      chk($sformatf("n13_%0d_valid", tag), ov13, 1);
      chk($sformatf("n13_%0d_idx%0d", tag, ptr), idx13, exp_q[ptr]);
      chk($sformatf("n13_%0d_last%0d", tag, ptr), ol13, (ptr == exp_q.size() - 1) ? 1 : 0);
      chk($sformatf("n13_%0d_none", tag), on13, (v == '0) ? 1 : 0);
      if (or13) ptr++;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) chk($sformatf("n13_%0d_timeout", tag), 0, 1);
    chk($sformatf("n13_%0d_idle_after", tag), ov13, 0);
    or13 = 1'b1;
  endtask

  rec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid8[d] = 1'b0; in_vec8[d] = '0; out_ready8[d] = 1'b1;
    end
    iv13 = 1'b0; vec13 = '0; or13 = 1'b1;

    tbl[0] = '{vec: 8'hA4, d: 0, beats: 3, exp: seq(7, 5, 2), none: 1'b0};
    tbl[1] = '{vec: 8'hA4, d: 1, beats: 3, exp: seq(2, 5, 7), none: 1'b0};
    tbl[2] = '{vec: 8'h18, d: 0, beats: 2, exp: seq(4, 3), none: 1'b0};
    tbl[3] = '{vec: 8'h18, d: 1, beats: 2, exp: seq(3, 4), none: 1'b0};
    tbl[4] = '{vec: 8'h00, d: 0, beats: 1, exp: seq(0), none: 1'b1};
    tbl[5] = '{vec: 8'h00, d: 1, beats: 1, exp: seq(0), none: 1'b1};
    tbl[6] = '{vec: 8'h81, d: 0, beats: 2, exp: seq(7, 0), none: 1'b0};
    tbl[7] = '{vec: 8'hFF, d: 1, beats: 8, exp: seq(0, 1, 2, 3, 4, 5, 6, 7), none: 1'b0};
    tbl[8] = '{vec: 8'h40, d: 0, beats: 1, exp: seq(6), none: 1'b0};

    #12;
    chk("rst_in_ready", in_ready8[0], 1);
    chk("rst_out_valid", out_valid8[0], 0);
    chk("rst_out_idx", out_idx8[0], 0);
    chk("rst_out_last", out_last8[0], 0);
    chk("rst_out_none", out_none8[0], 0);
    chk("rst_n13_out_valid", ov13, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) apply_rec(tbl[i], i);

    // Walking one-hot, each next vector offered on the previous last beat.
    in_vec8[0]   = 8'h01;
    in_valid8[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("walk%0d_valid", i), out_valid8[0], 1);
      chk($sformatf("walk%0d_idx", i), out_idx8[0], i);
      chk($sformatf("walk%0d_last", i), out_last8[0], 1);
      chk($sformatf("walk%0d_in_ready", i), in_ready8[0], 1);
      if (i < 7) in_vec8[0] = 8'(1 << (i + 1));
      else in_valid8[0] = 1'b0;
      @(posedge clk); #1;
    end
    chk("walk_idle_after", out_valid8[0], 0);

    // Backpressure: outputs hold, and a competing input is refused mid-scan.
    in_vec8[0]    = 8'h18;
    in_valid8[0]  = 1'b1;
    out_ready8[0] = 1'b0;
    @(posedge clk); #1;
    in_vec8[0] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_valid", i), out_valid8[0], 1);
      chk($sformatf("bp%0d_idx", i), out_idx8[0], 4);
      chk($sformatf("bp%0d_last", i), out_last8[0], 0);
      chk($sformatf("bp%0d_in_ready", i), in_ready8[0], 0);
      @(posedge clk); #1;
    end
    in_valid8[0]  = 1'b0;
    out_ready8[0] = 1'b1;
    chk("bp_rel_idx4", out_idx8[0], 4);
    chk("bp_rel_last4", out_last8[0], 0);
    @(posedge clk); #1;
    chk("bp_rel_idx3", out_idx8[0], 3);
    chk("bp_rel_last3", out_last8[0], 1);
    chk("bp_rel_in_ready", in_ready8[0], 1);
    @(posedge clk); #1;
    chk("bp_idle_after", out_valid8[0], 0);

    // Asynchronous reset mid-scan of 8'hFF.
    in_vec8[0]   = 8'hFF;
    in_valid8[0] = 1'b1;
    @(posedge clk); #1;
    in_valid8[0] = 1'b0;
    chk("ar_first_idx", out_idx8[0], 7);
    @(posedge clk); #1;
    chk("ar_second_idx", out_idx8[0], 6);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid8[0], 0);
    chk("ar_in_ready", in_ready8[0], 1);
    chk("ar_out_idx", out_idx8[0], 0);
    chk("ar_out_last", out_last8[0], 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    apply_rec('{vec: 8'h01, d: 0, beats: 1, exp: seq(0), none: 1'b0}, 100);

    // N=13: directed, zero, then random vectors with random stalls.
    run13(13'h1001, 1'b0, 0);
    run13(13'h0000, 1'b0, 1);
    for (int i = 0; i < 20; i++) run13(13'($urandom), 1'b1, 2 + i);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
